irrigation_countdown_timer: RTL and testbench



---
 rtl/irrigation_countdown_timer_pkg.sv | 24 ++
 rtl/irrigation_countdown_timer_if.sv | 29 ++
 rtl/irrigation_countdown_timer_bcd_digit_down.sv | 36 +++
 rtl/irrigation_countdown_timer.sv | 105 ++++++++++
 tb/tb_irrigation_countdown_timer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/irrigation_countdown_timer_pkg.sv
// Shared types and constants for the irrigation countdown timer.
//   state_t     : countdown FSM states (IDLE, RUN, EXPIRED)
//   bcd_t       : one 4-bit BCD digit
//   *_MIN_D/U   : minute digits of the sprinkler (15:00) and dripper (30:00) presets
//   DIGIT_MAX_* : wrap values used by the BCD borrow chain
package irrigation_countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SPRINKLER_MIN_D = 4'd1;
    localparam bcd_t SPRINKLER_MIN_U = 4'd5;
    localparam bcd_t DRIPPER_MIN_D   = 4'd3;
    localparam bcd_t DRIPPER_MIN_U   = 4'd0;

    localparam bcd_t DIGIT_MAX_9 = 4'd9;
    localparam bcd_t DIGIT_MAX_5 = 4'd5;

endpackage

// File: rtl/irrigation_countdown_timer_if.sv
// Control/display bundle of the irrigation countdown timer.
//   recount, splinker_mode_on, enable : controller -> timer
//   minutes_d/u, seconds_d/u          : BCD display digits, timer -> decoders
//   running, done                     : status, timer -> controller
// master = controller/bench side, slave = timer side.
interface irrigation_countdown_timer_if;
    import irrigation_countdown_timer_pkg::*;

    logic recount;
    logic splinker_mode_on;
    logic enable;
    bcd_t minutes_d;
    bcd_t minutes_u;
    bcd_t seconds_d;
    bcd_t seconds_u;
    logic running;
    logic done;

    modport master (
        output recount, splinker_mode_on, enable,
        input  minutes_d, minutes_u, seconds_d, seconds_u, running, done
    );

    modport slave (
        input  recount, splinker_mode_on, enable,
        output minutes_d, minutes_u, seconds_d, seconds_u, running, done
    );

endinterface

// File: rtl/irrigation_countdown_timer_bcd_digit_down.sv
// One registered BCD down-counting digit of the borrow chain.
//   clock, reset : system clock, synchronous active-high reset (digit -> 0)
//   load         : load load_value (wins over dec)
//   load_value   : value to load
//   dec          : decrement request (tick or borrow from the lower digit)
//   digit        : current digit value
//   borrow_out   : dec while digit is 0 -> the next-higher digit must decrement
module bcd_digit_down
    import irrigation_countdown_timer_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX_9
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  bcd_t load_value,
    input  logic dec,
    output bcd_t digit,
    output logic borrow_out
);

    // NOTE: sequential state is written with <= only, so every register in
    // the chain samples the pre-edge value of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_value;
        end else if (dec) begin
            digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
        end
    end

    assign borrow_out = dec && (digit == 4'd0);

endmodule

// File: rtl/irrigation_countdown_timer.sv
// BCD MM:SS countdown stage. A recount loads the preset (sprinkler 15:00,
// dripper 30:00) and starts counting down one second every TICKS_PER_SECOND
// enabled cycles; at 00:00 it stops and pulses done for one cycle.
//   clock : system clock
//   reset : synchronous active-high reset
//   bus   : irrigation_countdown_timer_if.slave (controls, digits, status)
module irrigation_countdown_timer
    import irrigation_countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SECOND = 50_000_000,
    parameter int PRESCALE_W       = 26
) (
    input  logic                        clock,
    input  logic                        reset,
    irrigation_countdown_timer_if.slave bus
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_SECOND - 1);

    state_t                state;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  running_q;
    logic                  done_q;

    bcd_t minutes_d, minutes_u, seconds_d, seconds_u;
    logic su_borrow, sd_borrow, mu_borrow, md_borrow_unused;

    // A tick only happens while running and enabled; a coincident recount
    // suppresses it so the preset load wins cleanly.
    logic tick;
    assign tick = (state == RUN) && bus.enable && !bus.recount
                  && (prescaler == PRESCALE_LAST);

    logic at_one_second;
    assign at_one_second = (minutes_d == 4'd0) && (minutes_u == 4'd0)
                           && (seconds_d == 4'd0) && (seconds_u == 4'd1);

    bcd_t preset_md, preset_mu;
    assign preset_md = bus.splinker_mode_on ? SPRINKLER_MIN_D : DRIPPER_MIN_D;
    assign preset_mu = bus.splinker_mode_on ? SPRINKLER_MIN_U : DRIPPER_MIN_U;

    bcd_digit_down #(.MAX(DIGIT_MAX_9)) u_seconds_u (
        .clock(clock), .reset(reset), .load(bus.recount), .load_value(4'd0),
        .dec(tick), .digit(seconds_u), .borrow_out(su_borrow)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX_5)) u_seconds_d (
        .clock(clock), .reset(reset), .load(bus.recount), .load_value(4'd0),
        .dec(su_borrow), .digit(seconds_d), .borrow_out(sd_borrow)
    );
    bcd_digit_down #(.MAX(DIGIT_MAX_9)) u_minutes_u (
        .clock(clock), .reset(reset), .load(bus.recount), .load_value(preset_mu),
        .dec(sd_borrow), .digit(minutes_u), .borrow_out(mu_borrow)
    );
    // The count stops at 00:00, so the top digit never borrows.
    bcd_digit_down #(.MAX(DIGIT_MAX_9)) u_minutes_d (
        .clock(clock), .reset(reset), .load(bus.recount), .load_value(preset_md),
        .dec(mu_borrow), .digit(minutes_d), .borrow_out(md_borrow_unused)
    );

    // NOTE: done defaults to 0 every cycle so it can only ever be a
    // single-cycle pulse from the final tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.recount) begin
                state     <= RUN;
                prescaler <= '0;
                running_q <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (bus.enable) begin
                            if (prescaler == PRESCALE_LAST) begin
                                prescaler <= '0;
                                if (at_one_second) begin
                                    state     <= EXPIRED;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end else begin
                                prescaler <= prescaler + 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and EXPIRED hold everything until a recount.
                    end
                endcase
            end
        end
    end

    assign bus.minutes_d = minutes_d;
    assign bus.minutes_u = minutes_u;
    assign bus.seconds_d = seconds_d;
    assign bus.seconds_u = seconds_u;
    assign bus.running   = running_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Scoreboard bench for irrigation_countdown_timer with TICKS_PER_SECOND=4.
// Stimulus pushes hand-computed expected display/status snapshots into a
// queue; a monitor pops and compares them on the falling edge.
module tb_irrigation_countdown_timer;
    import irrigation_countdown_timer_pkg::*;

    logic clock;
    logic reset;

    irrigation_countdown_timer_if bus();

    irrigation_countdown_timer #(
        .TICKS_PER_SECOND(4),
        .PRESCALE_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string name;
        bcd_t  md, mu, sd, su;
        logic  run;
        logic  dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    // Monitor: every falling edge, compare all pending expectations.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (bus.minutes_d !== cur.md || bus.minutes_u !== cur.mu ||
                bus.seconds_d !== cur.sd || bus.seconds_u !== cur.su ||
                bus.running !== cur.run || bus.done !== cur.dn) begin
                errors++;
                $display("FAIL %s: got %h%h:%h%h running=%b done=%b, expected %h%h:%h%h running=%b done=%b",
                         cur.name, bus.minutes_d, bus.minutes_u, bus.seconds_d, bus.seconds_u,
                         bus.running, bus.done, cur.md, cur.mu, cur.sd, cur.su, cur.run, cur.dn);
            end
        end
    end

    // Advance n rising edges, then settle 1 time unit before driving.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input bcd_t md, input bcd_t mu,
                              input bcd_t sd, input bcd_t su, input logic run, input logic dn);
        exp_t e;
        e.name = name; e.md = md; e.mu = mu; e.sd = sd; e.su = su; e.run = run; e.dn = dn;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset with every other input active: all must be ignored.
        reset = 1'b1;
        bus.recount = 1'b1;
        bus.splinker_mode_on = 1'b1;
        bus.enable = 1'b1;
        step(2);
        expect_out("reset", 0, 0, 0, 0, 1'b0, 1'b0);

        // Sprinkler load and first tick after 4 enabled cycles.
        reset = 1'b0;
        step(1);
        bus.recount = 1'b0;
        expect_out("sprinkler_load", 1, 5, 0, 0, 1'b1, 1'b0);
        step(3);
        expect_out("sprinkler_pre_tick", 1, 5, 0, 0, 1'b1, 1'b0);
        step(1);
        expect_out("sprinkler_tick", 1, 4, 5, 9, 1'b1, 1'b0);

        // Dripper reload from RUN, full borrow chain, then 10 ticks total.
        bus.recount = 1'b1;
        bus.splinker_mode_on = 1'b0;
        step(1);
        bus.recount = 1'b0;
        expect_out("dripper_load", 3, 0, 0, 0, 1'b1, 1'b0);
        step(4);
        expect_out("dripper_borrow", 2, 9, 5, 9, 1'b1, 1'b0);
        step(36);
        expect_out("dripper_10_ticks", 2, 9, 5, 0, 1'b1, 1'b0);

        // Pause with prescaler at 2; resume needs two more cycles for a tick.
        step(2);
        bus.enable = 1'b0;
        step(20);
        expect_out("pause_hold", 2, 9, 5, 0, 1'b1, 1'b0);
        bus.enable = 1'b1;
        step(1);
        expect_out("resume_no_tick_yet", 2, 9, 5, 0, 1'b1, 1'b0);
        step(1);
        expect_out("resume_tick", 2, 9, 4, 9, 1'b1, 1'b0);

        // Recount held high: preset reloaded every cycle, no counting.
        bus.recount = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            expect_out("recount_held", 3, 0, 0, 0, 1'b1, 1'b0);
        end

        // Expiry from 15:00; mode change mid-run must have no effect.
        bus.splinker_mode_on = 1'b1;
        step(1);
        bus.recount = 1'b0;
        bus.splinker_mode_on = 1'b0;
        expect_out("expiry_load", 1, 5, 0, 0, 1'b1, 1'b0);
        step(240);
        expect_out("one_minute_borrow", 1, 4, 0, 0, 1'b1, 1'b0);
        step(3359);
        expect_out("at_00_01", 0, 0, 0, 1, 1'b1, 1'b0);
        step(1);
        expect_out("expired_done", 0, 0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step(1);
            expect_out("expired_hold", 0, 0, 0, 0, 1'b0, 1'b0);
        end

        // Recount on the cycle of the final tick: preset wins, no done.
        bus.recount = 1'b1;
        bus.splinker_mode_on = 1'b1;
        step(1);
        bus.recount = 1'b0;
        expect_out("reload_from_expired", 1, 5, 0, 0, 1'b1, 1'b0);
        step(3599);
        expect_out("priority_at_00_01", 0, 0, 0, 1, 1'b1, 1'b0);
        bus.recount = 1'b1;
        bus.splinker_mode_on = 1'b0;
        step(1);
        bus.recount = 1'b0;
        expect_out("priority_recount_wins", 3, 0, 0, 0, 1'b1, 1'b0);
        step(1);
        expect_out("priority_no_late_done", 3, 0, 0, 0, 1'b1, 1'b0);

        // Reset mid-RUN, then stays IDLE even with enable high.
        step(5);
        expect_out("before_mid_reset", 2, 9, 5, 9, 1'b1, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_out("mid_run_reset", 0, 0, 0, 0, 1'b0, 1'b0);
        step(8);
        expect_out("idle_after_reset", 0, 0, 0, 0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
